// File: rtl/nonce_collector_mc.sv
// Shared nonce counter, round-robin golden-nonce queue and 128-bit host status frame for NUM_CORES hashcores.
// Latency: golden nonce reaches the FIFO 2 clk after its match; the host frame loads 1 clk after synchronised wr_start rises.
// Backpressure: a full FIFO stops grants, cores stay pending, and further matches on pending cores are dropped into ovf_cnt.
module nonce_collector_mc #(
    parameter int  NUM_CORES = 4,
    parameter int  GN_DEPTH  = 8,
    parameter int  PIPE_LAT  = 132,
    localparam int CORE_BITS = $clog2(NUM_CORES)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      nonce_clr,
    output logic [31-CORE_BITS:0]     nonce_base,
    input  logic [NUM_CORES-1:0]      gn_match,
    input  logic [32*NUM_CORES-1:0]   gn_in,
    input  logic [32*NUM_CORES-1:0]   hash_in,
    input  logic                      wr_start,
    input  logic                      wr_clk,
    output logic [7:0]                write
);
    localparam int NB_W = 32 - CORE_BITS;
    localparam int AW   = $clog2(GN_DEPTH);
    localparam int LW   = AW + 1;

    logic [CORE_BITS-1:0] phase, rr_ptr, grant_idx, cand;
    logic                 clr_q;
    logic [NUM_CORES-1:0] pending, granted, drop;
    logic [31:0]          pend_val [NUM_CORES];
    logic [7:0]           ovf_cnt, ovf_next;
    logic [31:0]          fifo_mem [GN_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic                 ws_b1, ws_b2;
    logic [3:0]           wc_b;
    logic [127:0]         outbuf;
    logic                 grant_vld, fifo_full, fifo_empty, push_ok, load, shift, pop;
    logic [31:0]          nonce_s, hash_s, head, status;

    assign fifo_full  = (level == LW'(GN_DEPTH));
    assign fifo_empty = (level == '0);
    assign load       = ws_b1 && !ws_b2;
    // One shift per wr_clk edge: edge seen at b0 while the older three stages still agree.
    assign shift      = (wc_b[3] == wc_b[2]) && (wc_b[2] == wc_b[1]) && (wc_b[1] != wc_b[0]);
    assign pop        = load && !fifo_empty;
    assign push_ok    = !fifo_full || pop;

    assign nonce_s = {nonce_base, phase} - 32'(PIPE_LAT);
    assign hash_s  = hash_in[{phase, 5'd0} +: 32];
    assign head    = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
    assign status  = {8'hB1, ovf_cnt, 8'(level), 7'd0, !fifo_empty};

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = rr_ptr + CORE_BITS'(i);
            if (!grant_vld && pending[cand] && push_ok) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A core being granted this clk is free to accept a new match in the same clk.
    always_comb begin
        granted  = '0;
        drop     = '0;
        ovf_next = ovf_cnt;
        for (int k = 0; k < NUM_CORES; k++) begin
            granted[k] = grant_vld && (grant_idx == CORE_BITS'(k));
            drop[k]    = gn_match[k] && pending[k] && !granted[k];
            if (drop[k] && ovf_next != 8'hFF)
                ovf_next = ovf_next + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nonce_base <= '0;
            phase      <= '0;
            clr_q      <= 1'b0;
        end else begin
            clr_q <= nonce_clr;
            if (nonce_clr)
                nonce_base <= '0;
            else
                nonce_base <= nonce_base + NB_W'(1);
            if (clr_q && !nonce_clr)
                phase <= phase + CORE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            rr_ptr  <= '0;
            ovf_cnt <= '0;
        end else if (nonce_clr) begin
            pending <= '0;
            rr_ptr  <= '0;
            ovf_cnt <= '0;
        end else begin
            ovf_cnt <= ovf_next;
            if (grant_vld)
                rr_ptr <= grant_idx + CORE_BITS'(1);
            for (int k = 0; k < NUM_CORES; k++) begin
                if (gn_match[k] && (!pending[k] || granted[k]))
                    pending[k] <= 1'b1;
                else if (granted[k])
                    pending[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CORES; k++) begin
            if (gn_match[k] && (!pending[k] || granted[k]))
                pend_val[k] <= gn_in[32*k +: 32];
        end
        if (grant_vld)
            fifo_mem[wr_ptr] <= pend_val[grant_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (nonce_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (grant_vld)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({grant_vld, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ws_b1  <= 1'b0;
            ws_b2  <= 1'b0;
            wc_b   <= '0;
            outbuf <= '0;
            write  <= '0;
        end else begin
            ws_b1 <= wr_start;
            ws_b2 <= ws_b1;
            wc_b  <= {wc_b[2:0], wr_clk};
            if (nonce_clr) begin
                outbuf <= '0;
                write  <= '0;
            end else begin
                if (load)
                    outbuf <= {status, head, hash_s, nonce_s};
                else if (shift)
                    outbuf <= {8'h00, outbuf[127:8]};
                write <= outbuf[7:0];
            end
        end
    end
endmodule

// File: tb/tb_nonce_collector_mc.sv
// Directed + randomized bench for nonce_collector_mc: a queue-based golden-nonce model and
// host frame reads through the wr_start / wr_clk byte interface.
module tb_nonce_collector_mc;
    localparam int NUM_CORES = 4;
    localparam int GN_DEPTH  = 8;
    localparam int PIPE_LAT  = 132;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         nonce_clr = 1'b0;
    logic         wr_start  = 1'b0;
    logic         wr_clk    = 1'b0;
    logic [3:0]   gn_match  = '0;
    logic [127:0] gn_in     = '0;
    logic [127:0] hash_in   = '0;
    logic [29:0]  nonce_base;
    logic [7:0]   write;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nb_origin = 0;

    logic [31:0] q[$];
    bit          m_pend [NUM_CORES];
    logic [31:0] m_pval [NUM_CORES];
    int          m_rr    = 0;
    int          m_ovf   = 0;
    int          m_phase = 0;

    nonce_collector_mc #(.NUM_CORES(NUM_CORES), .GN_DEPTH(GN_DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .nonce_clr(nonce_clr), .nonce_base(nonce_base),
        .gn_match(gn_match), .gn_in(gn_in), .hash_in(hash_in),
        .wr_start(wr_start), .wr_clk(wr_clk), .write(write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pending values enter the queue in round-robin order while there is room.
    function automatic void m_drain();
        bit moved = 1'b1;
        while (moved) begin
            moved = 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                int k = (m_rr + i) % NUM_CORES;
                if (m_pend[k] && q.size() < GN_DEPTH) begin
                    q.push_back(m_pval[k]);
                    m_pend[k] = 1'b0;
                    m_rr  = (k + 1) % NUM_CORES;
                    moved = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic void m_clear();
        q.delete();
        for (int k = 0; k < NUM_CORES; k++) m_pend[k] = 1'b0;
        m_rr  = 0;
        m_ovf = 0;
    endfunction

    task automatic fire(input logic [3:0] mask, input logic [127:0] vals);
        @(negedge clk);
        gn_match = mask;
        gn_in    = vals;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (mask[k]) begin
                if (m_pend[k]) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    m_pend[k] = 1'b1;
                    m_pval[k] = vals[32*k +: 32];
                end
            end
        end
        m_drain();
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        gn_match = '0;
        repeat (n) @(posedge clk);
    endtask

    task automatic toggle_wr_clk();
        @(negedge clk);
        wr_clk = ~wr_clk;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input bit coincide, input string tag,
                            output logic [127:0] f, output logic [29:0] nb_seen);
        logic [7:0]  b [17];
        logic [31:0] e_nonce, e_hash, e_head;
        logic [29:0] e_nb;
        int          e_lvl;
        bit          e_hv;
        @(negedge clk);
        for (int k = 0; k < NUM_CORES; k++) hash_in[32*k +: 32] = $urandom;
        wr_start = 1'b1;
        if (coincide) wr_clk = ~wr_clk;
        @(posedge clk);
        #1;
        nb_seen = nonce_base;
        e_nb    = 30'(cyc - nb_origin);
        chk({tag, "/nonce_base"}, 128'(nonce_base), 128'(e_nb));
        e_nonce = {e_nb, 2'(m_phase)} - 32'(PIPE_LAT);
        e_hash  = hash_in[32*m_phase +: 32];
        e_lvl   = q.size();
        e_hv    = (q.size() > 0);
        e_head  = e_hv ? q.pop_front() : 32'd0;
        m_drain();
        @(posedge clk);
        @(negedge clk);
        wr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b[0] = write;
        for (int i = 1; i < 17; i++) begin
            toggle_wr_clk();
            b[i] = write;
        end
        for (int i = 0; i < 16; i++) f[8*i +: 8] = b[i];
        chk({tag, "/nonce_s"}, 128'(f[31:0]), 128'(e_nonce));
        chk({tag, "/hash_s"}, 128'(f[63:32]), 128'(e_hash));
        chk({tag, "/head"}, 128'(f[95:64]), 128'(e_head));
        chk({tag, "/status"}, 128'(f[127:96]), 128'({8'hB1, 8'(m_ovf), 8'(e_lvl), 7'd0, e_hv}));
        chk({tag, "/byte15"}, 128'(b[15]), 128'(8'hB1));
        chk({tag, "/byte16"}, 128'(b[16]), 128'(8'h00));
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        nonce_clr = 1'b1;
        @(negedge clk);
        nonce_clr = 1'b0;
        nb_origin = cyc;
        m_phase   = (m_phase + 1) % NUM_CORES;
        m_clear();
    endtask

    initial begin
        logic [127:0] f, v;
        logic [29:0]  nb;
        logic [3:0]   mask;
        int           nq;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", 128'(write), 128'(0));
        chk("rst_nonce_base", 128'(nonce_base), 128'(0));
        @(negedge clk);
        reset_n   = 1'b1;
        nb_origin = cyc;
        repeat (9) @(posedge clk);
        do_frame(1'b0, "first", f, nb);
        chk("nb_after_10clk", 128'(nb), 128'(10));
        // {10, 2'b00} - 132, 32-bit modular
        chk("nonce_s_nb10", 128'(f[31:0]), 128'(32'hFFFFFFA4));

        for (int k = 0; k < NUM_CORES; k++) v[32*k +: 32] = 32'(100 + k);
        fire(4'b1111, v);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            do_frame(1'b0, "simul", f, nb);
            chk("simul_order", 128'(f[95:64]), 128'(100 + i));
        end
        do_frame(1'b0, "simul_empty", f, nb);

        fire(4'b0010, {96'd0, 32'hA5A5_0001, 32'd0});
        fire(4'b0010, {96'd0, 32'hA5A5_0002, 32'd0});
        idle(8);
        do_frame(1'b0, "b2b_a", f, nb);
        do_frame(1'b0, "b2b_b", f, nb);
        do_frame(1'b0, "b2b_empty", f, nb);

        for (int r = 0; r < 3; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < NUM_CORES; k++) v[32*k +: 32] = $urandom;
            fire(mask, v);
            idle(8);
            nq = q.size();
            for (int i = 0; i <= nq; i++)
                do_frame((r == 1) && (i == 0), "rand", f, nb);
        end

        for (int i = 0; i < 12; i++) begin
            fire(4'b0100, {32'd0, 32'h2000_0000 + 32'(i), 64'd0});
            idle(2);
        end
        do_frame(1'b0, "ovf12", f, nb);
        chk("ovf12_cnt", 128'(f[119:112]), 128'(3));
        for (int i = 0; i < 300; i++) fire(4'b0001, {96'd0, 32'h3000_0000 + 32'(i)});
        idle(4);
        do_frame(1'b0, "ovf_sat", f, nb);
        chk("ovf_sat_cnt", 128'(f[119:112]), 128'(255));
        nq = q.size();
        for (int i = 0; i <= nq; i++) do_frame(1'b0, "drain", f, nb);

        clr_pulse();
        do_frame(1'b0, "phase1", f, nb);
        clr_pulse();
        do_frame(1'b0, "phase2", f, nb);
        chk("phase2_hash_core2", 128'(f[63:32]), 128'(hash_in[95:64]));

        for (int i = 0; i < 10; i++) begin
            fire(4'b1000, {32'h4000_0000 + 32'(i), 96'd0});
            idle(2);
        end
        @(negedge clk);
        wr_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_start = 1'b0;
        toggle_wr_clk();
        toggle_wr_clk();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midframe_rst_write", 128'(write), 128'(0));
        @(negedge clk);
        reset_n   = 1'b1;
        nb_origin = cyc;
        m_phase   = 0;
        m_clear();
        toggle_wr_clk();
        toggle_wr_clk();
        chk("post_rst_outbuf", 128'(write), 128'(0));
        do_frame(1'b0, "post_rst", f, nb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
